sys_time_ctrl: RTL and testbench

Runs the free-running system time-of-day counter in the trn_clk domain and keeps it synchronised to host-programmed time. The sys_time block decodes host writes for seconds and nanoseconds; this block coalesces those into one atomic load. It then shares the live timestamp between two requesters (RX timestamping paths) through a round-robin req/gnt arbiter.

---
 rtl/sys_time_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sys_time_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_time_ctrl.sv
// System time-of-day counter with atomic host load and
// round-robin timestamp arbiter for two RX requesters.
module sys_time_ctrl #(
    parameter int unsigned NS_PER_TICK = 4,
    parameter int unsigned NS_PER_SEC  = 1000000000,
    parameter int unsigned LOAD_HOLD   = 16
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic [31:0] host_nsecs,
    input  logic [31:0] host_secs,
    input  logic        rx_timestamp_en,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [31:0] ts_nsecs,
    output logic [31:0] ts_secs,
    output logic        ts_valid,
    output logic [31:0] cur_nsecs,
    output logic [31:0] cur_secs,
    output logic        time_valid,
    output logic        load_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COMMIT
    } state_t;

    localparam logic [31:0] NSEC_MAX  = 32'(NS_PER_SEC);
    localparam logic [31:0] NSEC_STEP = 32'(NS_PER_TICK);
    localparam logic [8:0]  HOLD_LAST = 9'(LOAD_HOLD - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_nxt;
    logic [31:0] r_prev_nsecs;
    logic [31:0] r_prev_secs;
    logic [31:0] r_cur_nsecs;
    logic [31:0] r_cur_secs;
    logic        r_time_valid;
    logic        r_load_err;
    logic        w_change;
    logic        w_commit;
    logic        w_load_ok;
    logic        w_load_bad;
    logic [31:0] w_ns_sum;
    logic        w_ns_wrap;

    logic [1:0]  r_gnt;
    logic        r_ptr;
    logic [31:0] r_ts_nsecs;
    logic [31:0] r_ts_secs;
    logic        r_ts_valid;
    logic [1:0]  w_elig;
    logic [1:0]  w_gnt_nxt;
    logic        w_ptr_nxt;

    assign w_change   = (host_nsecs != r_prev_nsecs) ||
                        (host_secs != r_prev_secs);
    assign w_load_ok  = w_commit && (host_nsecs < NSEC_MAX);
    assign w_load_bad = w_commit && !(host_nsecs < NSEC_MAX);
    assign w_ns_sum   = r_cur_nsecs + NSEC_STEP;
    assign w_ns_wrap  = (w_ns_sum >= NSEC_MAX);

    // Track last host values every cycle, reset included, so that
    // host values present at reset release never look like a change.
    always_ff @(posedge trn_clk) begin
        r_prev_nsecs <= host_nsecs;
        r_prev_secs  <= host_secs;
    end

    // Load FSM state register.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Load FSM: wait for host values to settle, then commit once.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_change) begin
                    w_state_nxt = S_SETTLE;
                    w_hold_nxt  = 8'd0;
                end
            end
            S_SETTLE: begin
                if (w_change) begin
                    w_hold_nxt = 8'd0;
                end else if ({1'b0, r_hold_cnt} + 9'd1 >= HOLD_LAST) begin
                    w_state_nxt = S_COMMIT;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                if (w_change) begin
                    w_state_nxt = S_SETTLE;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    // Free-running time counter; a good commit replaces the increment.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_cur_nsecs  <= 32'd0;
            r_cur_secs   <= 32'd0;
            r_time_valid <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_cur_nsecs  <= host_nsecs;
                r_cur_secs   <= host_secs;
                r_time_valid <= 1'b1;
            end else if (w_ns_wrap) begin
                r_cur_nsecs <= w_ns_sum - NSEC_MAX;
                r_cur_secs  <= r_cur_secs + 32'd1;
            end else begin
                r_cur_nsecs <= w_ns_sum;
            end
        end
    end

    // Round-robin choice; a requester just granted sits out one cycle.
    always_comb begin
        w_elig    = req & ~r_gnt;
        w_gnt_nxt = 2'b00;
        w_ptr_nxt = r_ptr;
        unique case (w_elig)
            2'b01: w_gnt_nxt = 2'b01;
            2'b10: w_gnt_nxt = 2'b10;
            2'b11: begin
                w_gnt_nxt = r_ptr ? 2'b10 : 2'b01;
                w_ptr_nxt = ~r_ptr;
            end
            default: w_gnt_nxt = 2'b00;
        endcase
    end

    // Grant register and snapshot of the pre-update time.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_gnt      <= 2'b00;
            r_ptr      <= 1'b0;
            r_ts_nsecs <= 32'd0;
            r_ts_secs  <= 32'd0;
            r_ts_valid <= 1'b0;
        end else begin
            r_gnt <= w_gnt_nxt;
            r_ptr <= w_ptr_nxt;
            if (|w_gnt_nxt) begin
                r_ts_nsecs <= r_cur_nsecs;
                r_ts_secs  <= r_cur_secs;
                r_ts_valid <= rx_timestamp_en & r_time_valid;
            end
        end
    end

    assign gnt        = r_gnt;
    assign ts_nsecs   = r_ts_nsecs;
    assign ts_secs    = r_ts_secs;
    assign ts_valid   = r_ts_valid;
    assign cur_nsecs  = r_cur_nsecs;
    assign cur_secs   = r_cur_secs;
    assign time_valid = r_time_valid;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_sys_time_ctrl.sv
// Self-checking bench for sys_time_ctrl: reference time model plus
// a grant scoreboard filled when requests are driven.
module tb_sys_time_ctrl;

    localparam int unsigned LOAD_HOLD = 16;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic [31:0] host_nsecs;
    logic [31:0] host_secs;
    logic        rx_timestamp_en;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [31:0] ts_nsecs;
    logic [31:0] ts_secs;
    logic        ts_valid;
    logic [31:0] cur_nsecs;
    logic [31:0] cur_secs;
    logic        time_valid;
    logic        load_err;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] ns;
        logic [31:0] s;
        logic        v;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_ns;
    logic [31:0] ref_s;
    logic        ref_tv;

    sys_time_ctrl #(
        .NS_PER_TICK(4),
        .NS_PER_SEC(1000000000),
        .LOAD_HOLD(LOAD_HOLD)
    ) dut (
        .trn_clk(trn_clk),
        .reset(reset),
        .host_nsecs(host_nsecs),
        .host_secs(host_secs),
        .rx_timestamp_en(rx_timestamp_en),
        .req(req),
        .gnt(gnt),
        .ts_nsecs(ts_nsecs),
        .ts_secs(ts_secs),
        .ts_valid(ts_valid),
        .cur_nsecs(cur_nsecs),
        .cur_secs(cur_secs),
        .time_valid(time_valid),
        .load_err(load_err)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; reference time follows reset / load / increment.
    task automatic tick(input bit ld);
        @(posedge trn_clk);
        if (reset) begin
            ref_ns = 0;
            ref_s  = 0;
            ref_tv = 0;
        end else if (ld) begin
            ref_ns = host_nsecs;
            ref_s  = host_secs;
            ref_tv = 1;
        end else begin
            ref_ns = ref_ns + 32'd4;
            if (ref_ns >= 32'd1000000000) begin
                ref_ns = ref_ns - 32'd1000000000;
                ref_s  = ref_s + 32'd1;
            end
        end
        #1;
    endtask

    task automatic chk_time(input string tag);
        chk({tag, "_ns"}, cur_nsecs, ref_ns);
        chk({tag, "_s"}, cur_secs, ref_s);
        chk({tag, "_tv"}, time_valid, ref_tv);
    endtask

    // Push the grant expected for this cycle's req, then compare it.
    task automatic gstep(input logic [1:0] g_exp);
        exp_t e;
        exp_t o;
        e.g  = g_exp;
        e.ns = ref_ns;
        e.s  = ref_s;
        e.v  = rx_timestamp_en & ref_tv;
        sb_q.push_back(e);
        tick(0);
        o = sb_q.pop_front();
        chk("gnt", gnt, o.g);
        if (o.g != 2'b00) begin
            chk("ts_ns", ts_nsecs, o.ns);
            chk("ts_s", ts_secs, o.s);
            chk("ts_valid", ts_valid, o.v);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        host_nsecs      = 32'd0;
        host_secs       = 32'd0;
        rx_timestamp_en = 1'b0;
        req             = 2'b00;
        ref_ns          = 0;
        ref_s           = 0;
        ref_tv          = 0;
        repeat (3) tick(0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_ts_valid", ts_valid, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        chk_time("rst");
        reset = 1'b0;

        repeat (10) tick(0);
        chk("idle_ns_40", cur_nsecs, 32'd40);
        chk("idle_s_0", cur_secs, 32'd0);
        chk("idle_tv", time_valid, 1'b0);
        chk("idle_gnt", gnt, 2'b00);

        host_nsecs = 32'd999999990;
        repeat (3) tick(0);
        host_secs = 32'd5;
        repeat (LOAD_HOLD) tick(0);
        chk_time("pre_commit");
        tick(1);
        chk("load_ns", cur_nsecs, 32'd999999990);
        chk("load_s", cur_secs, 32'd5);
        chk("load_tv", time_valid, 1'b1);
        tick(0);
        chk_time("after_load1");
        tick(0);
        chk("after_load2_ns", cur_nsecs, 32'd999999998);
        tick(0);
        chk("wrap_ns", cur_nsecs, 32'd2);
        chk("wrap_s", cur_secs, 32'd6);

        host_nsecs = 32'd1000000000;
        repeat (LOAD_HOLD) tick(0);
        chk("err_before", load_err, 1'b0);
        tick(0);
        chk("err_pulse", load_err, 1'b1);
        chk_time("err_time");
        tick(0);
        chk("err_clear", load_err, 1'b0);

        rx_timestamp_en = 1'b1;
        req = 2'b11;
        gstep(2'b01);
        gstep(2'b10);
        gstep(2'b01);
        gstep(2'b10);
        req = 2'b00;
        gstep(2'b00);
        gstep(2'b00);

        rx_timestamp_en = 1'b0;
        req = 2'b01;
        gstep(2'b01);
        gstep(2'b00);
        gstep(2'b01);
        gstep(2'b00);
        req = 2'b00;
        gstep(2'b00);
        chk_time("arb_end");

        rx_timestamp_en = 1'b1;
        host_nsecs = 32'd123;
        tick(0);
        tick(0);
        req = 2'b10;
        gstep(2'b10);
        reset = 1'b1;
        host_nsecs = 32'd456;
        tick(0);
        chk("mid_rst_gnt", gnt, 2'b00);
        chk_time("mid_rst");
        req = 2'b00;
        tick(0);
        reset = 1'b0;
        repeat (LOAD_HOLD + 4) tick(0);
        chk_time("post_rst");
        chk("post_rst_err", load_err, 1'b0);
        req = 2'b11;
        gstep(2'b01);
        req = 2'b00;
        tick(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
